mac_operand_feeder: RTL



---
 rtl/npu_pkg.sv | 17 +
 rtl/feeder_bank.sv | 51 +++++
 rtl/mac_operand_feeder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU datapath types: operand width and the {a, b} pair carried
// from the operand feeder into the MAC and result collector.
package npu_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  // Index counter width: at least one bit even for tiny vectors.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// One operand bank: N {a, b} entries plus a full flag. The bank is written
// at the index supplied by the feeder; wr_last marks the write that fills it
// and rd_done marks the drain handshake of its final entry.
module feeder_bank
  import npu_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_last,
  input  pair_t            wr_pair,
  input  logic             rd_done,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             full,
  output pair_t            rd_pair
);

  pair_t mem [N];

  // Pair storage; contents survive flush because they are unreadable until refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_pair;
    end
  end

  // Full flag: set by the filling write, cleared by the final drain or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (wr_en && wr_last) begin
      full <= 1'b1;
    end else if (rd_done) begin
      full <= 1'b0;
    end
  end

  assign rd_pair = mem[rd_idx];

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the MAC: gathers N {a, b} pairs per vector and streams
// them out one per cycle with first/last markers.
// Build option: define FEEDER_DOUBLE_BUFFER_EN for two ping-pong banks so a
// new vector loads while the previous one drains; otherwise one bank.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_ready never depends on in_valid and out_valid never depends on
// out_ready; payload and flags hold steady while out_valid && !out_ready.
module mac_operand_feeder
  import npu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_first,
  output logic              out_last
);

  localparam int               IDX_W    = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Only one bank is written and one drained at a time, and each index
  // returns to 0 when its bank completes, so a single pair of indices
  // serves every bank. wr_idx doubles as the fill count of the write bank.
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_last;
  logic             rd_last;
  logic             accept;
  logic             drain;
  logic             wr_full;
  logic             rd_full;
  pair_t            in_pair;
  pair_t            rd_pair;

  assign in_pair   = '{a: in_a, b: in_b};
  assign wr_last   = (wr_idx == LAST_IDX);
  assign rd_last   = (rd_idx == LAST_IDX);

  // Reset and flush both suppress the handshakes so nothing moves that cycle.
  assign in_ready  = !rst && !flush && !wr_full;
  assign out_valid = !rst && !flush && rd_full;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Outputs read zero whenever no pair is presented.
  assign out_a     = out_valid ? rd_pair.a : '0;
  assign out_b     = out_valid ? rd_pair.b : '0;
  assign out_first = out_valid && (rd_idx == '0);
  assign out_last  = out_valid && rd_last;

  // Write/read indices wrap through the explicit last-index compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (accept) begin
        wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
      end
      if (drain) begin
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      end
    end
  end

`ifdef FEEDER_DOUBLE_BUFFER_EN

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] bank_full;
  pair_t      bank_pair [2];

  // Bank pointers flip when the write bank fills or the read bank empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept && wr_last) begin
        wr_ptr <= ~wr_ptr;
      end
      if (drain && rd_last) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    localparam logic SEL = 1'(g);
    feeder_bank #(.N(N)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .wr_en   (accept && (wr_ptr == SEL)),
      .wr_idx  (wr_idx),
      .wr_last (wr_last),
      .wr_pair (in_pair),
      .rd_done (drain && rd_last && (rd_ptr == SEL)),
      .rd_idx  (rd_idx),
      .full    (bank_full[g]),
      .rd_pair (bank_pair[g])
    );
  end

  assign wr_full = bank_full[wr_ptr];
  assign rd_full = bank_full[rd_ptr];
  assign rd_pair = bank_pair[rd_ptr];

`else

  logic bank_full;

  // Single bank: it is either filling or draining, never both.
  feeder_bank #(.N(N)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (accept),
    .wr_idx  (wr_idx),
    .wr_last (wr_last),
    .wr_pair (in_pair),
    .rd_done (drain && rd_last),
    .rd_idx  (rd_idx),
    .full    (bank_full),
    .rd_pair (rd_pair)
  );

  assign wr_full = bank_full;
  assign rd_full = bank_full;

`endif

endmodule
